// File: rtl/lsu_dmem_master_if.sv
// Core request/response handshake plus data-memory port of the LSU.
// master = LSU side, slave = core + memory side.
interface lsu_dmem_master_if #(
    parameter int ADDR_W = 16
);
    logic              req_valid;
    logic              req_ready;
    logic              req_we;
    logic [2:0]        req_funct3;
    logic [ADDR_W-1:0] req_addr;
    logic [31:0]       req_wdata;

    logic              rsp_valid;
    logic [31:0]       rsp_rdata;
    logic              rsp_err;

    logic [ADDR_W-3:0] mem_rd_addr;
    logic [31:0]       mem_rd_dout;
    logic [ADDR_W-3:0] mem_wr_addr;
    logic [31:0]       mem_wr_din;
    logic              mem_we;
    logic [3:0]        mem_be;

    modport master (
        input  req_valid, req_we, req_funct3, req_addr, req_wdata, mem_rd_dout,
        output req_ready, rsp_valid, rsp_rdata, rsp_err,
               mem_rd_addr, mem_wr_addr, mem_wr_din, mem_we, mem_be
    );

    modport slave (
        output req_valid, req_we, req_funct3, req_addr, req_wdata, mem_rd_dout,
        input  req_ready, rsp_valid, rsp_rdata, rsp_err,
               mem_rd_addr, mem_wr_addr, mem_wr_din, mem_we, mem_be
    );
endinterface

// File: rtl/lsu_dmem_master.sv
// LSU data-memory initiator: one request at a time, byte-lane store formatting,
// load extraction/extension, misaligned accesses split across two words.
module lsu_dmem_master #(
    parameter int ADDR_W           = 16,
    parameter bit ALLOW_MISALIGNED = 1'b1
) (
    input  logic              clk,
    input  logic              rst,
    lsu_dmem_master_if.master bus
);
    localparam int WA_W = ADDR_W - 2;

    typedef enum logic [2:0] {IDLE, RD0, RD1, LDRSP, WR0, WR1, RSP} state_t;

    state_t          state_q, state_d;
    logic [2:0]      f3_q, f3_d;
    logic [1:0]      off_q, off_d;
    logic            split_q, split_d;
    logic [WA_W-1:0] wa_q, wa_d;
    logic [3:0]      hi_be_q, hi_be_d;
    logic [31:0]     hi_din_q, hi_din_d;
    logic [31:0]     lo_q, lo_d;

    logic [WA_W-1:0] rd_addr_q, rd_addr_d;
    logic [WA_W-1:0] wr_addr_q, wr_addr_d;
    logic [31:0]     wr_din_q, wr_din_d;
    logic            we_q, we_d;
    logic [3:0]      be_q, be_d;
    logic            rsp_valid_q, rsp_valid_d;
    logic [31:0]     rsp_rdata_q, rsp_rdata_d;
    logic            rsp_err_q, rsp_err_d;

    // Request decode: lane mask spread over two words tells us whether it splits.
    logic [3:0]  req_mask;
    logic [7:0]  req_be8;
    logic [63:0] req_din64;
    logic        req_legal, req_split, req_err;

    always_comb begin
        unique case (bus.req_funct3[1:0])
            2'b00:   req_mask = 4'b0001;
            2'b01:   req_mask = 4'b0011;
            2'b10:   req_mask = 4'b1111;
            default: req_mask = 4'b0000;
        endcase
        req_be8   = {4'b0000, req_mask} << bus.req_addr[1:0];
        req_din64 = {32'd0, bus.req_wdata} << {bus.req_addr[1:0], 3'b000};
        req_split = |req_be8[7:4];
        if (bus.req_we)
            req_legal = (bus.req_funct3[2] == 1'b0) && (bus.req_funct3[1:0] != 2'b11);
        else
            req_legal = bus.req_funct3 inside {3'b000, 3'b001, 3'b010, 3'b100, 3'b101};
        req_err = !req_legal || (req_split && !ALLOW_MISALIGNED);
    end

    // Load assembly: word W sits in the low half, W+1 (if split) in the high half.
    logic [63:0] ld_pair;
    logic [31:0] ld_raw, ld_ext;

    always_comb begin
        ld_pair = (split_q ? {bus.mem_rd_dout, lo_q} : {32'd0, bus.mem_rd_dout})
                  >> {off_q, 3'b000};
        ld_raw  = ld_pair[31:0];
        unique case (f3_q)
            3'b000:  ld_ext = {{24{ld_raw[7]}}, ld_raw[7:0]};
            3'b001:  ld_ext = {{16{ld_raw[15]}}, ld_raw[15:0]};
            3'b100:  ld_ext = {24'd0, ld_raw[7:0]};
            3'b101:  ld_ext = {16'd0, ld_raw[15:0]};
            default: ld_ext = ld_raw;
        endcase
    end

    always_comb begin
        state_d     = state_q;
        f3_d        = f3_q;
        off_d       = off_q;
        split_d     = split_q;
        wa_d        = wa_q;
        hi_be_d     = hi_be_q;
        hi_din_d    = hi_din_q;
        lo_d        = lo_q;
        rd_addr_d   = rd_addr_q;
        wr_addr_d   = wr_addr_q;
        wr_din_d    = wr_din_q;
        we_d        = 1'b0;
        be_d        = 4'b0000;
        rsp_valid_d = 1'b0;
        rsp_rdata_d = rsp_rdata_q;
        rsp_err_d   = rsp_err_q;

        unique case (state_q)
            IDLE: begin
                if (bus.req_valid) begin
                    f3_d     = bus.req_funct3;
                    off_d    = bus.req_addr[1:0];
                    split_d  = req_split;
                    wa_d     = bus.req_addr[ADDR_W-1:2];
                    hi_be_d  = req_be8[7:4];
                    hi_din_d = req_din64[63:32];
                    if (req_err) begin
                        rsp_valid_d = 1'b1;
                        rsp_err_d   = 1'b1;
                        rsp_rdata_d = 32'd0;
                    end else if (bus.req_we) begin
                        state_d   = WR0;
                        we_d      = 1'b1;
                        be_d      = req_be8[3:0];
                        wr_addr_d = bus.req_addr[ADDR_W-1:2];
                        wr_din_d  = req_din64[31:0];
                    end else begin
                        state_d   = RD0;
                        rd_addr_d = bus.req_addr[ADDR_W-1:2];
                    end
                end
            end
            RD0: begin
                if (split_q) begin
                    state_d   = RD1;
                    rd_addr_d = wa_q + WA_W'(1);
                end else begin
                    state_d = LDRSP;
                end
            end
            RD1: begin
                lo_d    = bus.mem_rd_dout;
                state_d = LDRSP;
            end
            LDRSP: begin
                state_d     = IDLE;
                rsp_valid_d = 1'b1;
                rsp_err_d   = 1'b0;
                rsp_rdata_d = ld_ext;
            end
            WR0: begin
                if (split_q) begin
                    state_d   = WR1;
                    we_d      = 1'b1;
                    be_d      = hi_be_q;
                    wr_addr_d = wa_q + WA_W'(1);
                    wr_din_d  = hi_din_q;
                end else begin
                    state_d     = IDLE;
                    rsp_valid_d = 1'b1;
                    rsp_err_d   = 1'b0;
                    rsp_rdata_d = 32'd0;
                end
            end
            WR1: begin
                state_d     = IDLE;
                rsp_valid_d = 1'b1;
                rsp_err_d   = 1'b0;
                rsp_rdata_d = 32'd0;
            end
            // The response is registered on the return to IDLE so the core can
            // hand over the next request in the response cycle; RSP just recovers.
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= IDLE;
            f3_q        <= '0;
            off_q       <= '0;
            split_q     <= 1'b0;
            wa_q        <= '0;
            hi_be_q     <= '0;
            hi_din_q    <= '0;
            lo_q        <= '0;
            rd_addr_q   <= '0;
            wr_addr_q   <= '0;
            wr_din_q    <= '0;
            we_q        <= 1'b0;
            be_q        <= '0;
            rsp_valid_q <= 1'b0;
            rsp_rdata_q <= '0;
            rsp_err_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            f3_q        <= f3_d;
            off_q       <= off_d;
            split_q     <= split_d;
            wa_q        <= wa_d;
            hi_be_q     <= hi_be_d;
            hi_din_q    <= hi_din_d;
            lo_q        <= lo_d;
            rd_addr_q   <= rd_addr_d;
            wr_addr_q   <= wr_addr_d;
            wr_din_q    <= wr_din_d;
            we_q        <= we_d;
            be_q        <= be_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_rdata_q <= rsp_rdata_d;
            rsp_err_q   <= rsp_err_d;
        end
    end

    assign bus.req_ready   = (state_q == IDLE);
    assign bus.rsp_valid   = rsp_valid_q;
    assign bus.rsp_rdata   = rsp_rdata_q;
    assign bus.rsp_err     = rsp_err_q;
    assign bus.mem_rd_addr = rd_addr_q;
    assign bus.mem_wr_addr = wr_addr_q;
    assign bus.mem_wr_din  = wr_din_q;
    assign bus.mem_we      = we_q;
    assign bus.mem_be      = be_q;
endmodule
